instr_fetch_unit: RTL

- Front-end stage directly upstream of program memory.
- Owns the 12-bit program counter and drives the memory's asynchronous read address.
- Registers the returned 32-bit instruction into a valid/ready output slot for the decode/execute stage.
- Resolves unconditional jumps locally, accepts branch redirects from execute, and stops fetching after a halt.

---
 rtl/risc_pkg.sv | 41 ++++
 rtl/instr_fetch_unit_if.sv | 27 ++
 rtl/fetch_next_pc.sv | 24 ++
 rtl/instr_fetch_unit.sv | 105 ++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared definitions for the RISC front end: opcodes, instruction field positions,
// datapath widths and the fetch state encoding.
package risc_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 12;

    localparam logic [7:0] OP_LDD   = 8'h01;
    localparam logic [7:0] OP_LDI   = 8'h02;
    localparam logic [7:0] OP_LDIMM = 8'h03;
    localparam logic [7:0] OP_ST    = 8'h04;
    localparam logic [7:0] OP_STI   = 8'h05;
    localparam logic [7:0] OP_ADD   = 8'h06;
    localparam logic [7:0] OP_SUB   = 8'h07;
    localparam logic [7:0] OP_MUL   = 8'h08;
    localparam logic [7:0] OP_AND   = 8'h09;
    localparam logic [7:0] OP_OR    = 8'h0A;
    localparam logic [7:0] OP_NOT   = 8'h0B;
    localparam logic [7:0] OP_GT    = 8'h0C;
    localparam logic [7:0] OP_EQ    = 8'h0D;
    localparam logic [7:0] OP_JMP   = 8'h0E;
    localparam logic [7:0] OP_JNE   = 8'h0F;
    localparam logic [7:0] OP_HALT  = 8'hFF;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 24;
    localparam int RD_MSB     = 23;
    localparam int RD_LSB     = 20;
    localparam int RS1_MSB    = 19;
    localparam int RS1_LSB    = 16;
    localparam int RS2_MSB    = 15;
    localparam int RS2_LSB    = 12;
    localparam int IMM_MSB    = 11;
    localparam int IMM_LSB    = 0;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: program memory port, decode-side valid/ready slot, redirect input
// and halt status. master = fetch unit, slave = memory/execute environment.
interface instr_fetch_unit_if #(
    parameter int INSTR_W = risc_pkg::INSTR_W,
    parameter int PC_W    = risc_pkg::PC_W
);
    logic               fetch_en;
    logic [PC_W-1:0]    program_addr;
    logic [INSTR_W-1:0] instruction;
    logic               inst_valid;
    logic               inst_ready;
    logic [INSTR_W-1:0] inst_out;
    logic [PC_W-1:0]    inst_pc;
    logic               redirect_valid;
    logic [PC_W-1:0]    redirect_addr;
    logic               halted;

    modport master (
        input  fetch_en, instruction, inst_ready, redirect_valid, redirect_addr,
        output program_addr, inst_valid, inst_out, inst_pc, halted
    );

    modport slave (
        output fetch_en, instruction, inst_ready, redirect_valid, redirect_addr,
        input  program_addr, inst_valid, inst_out, inst_pc, halted
    );
endinterface

// File: rtl/fetch_next_pc.sv
// Combinational next-PC select: redirect beats everything, then a loaded jump takes
// its immediate, otherwise a loaded word advances the PC by one (wrapping).
module fetch_next_pc #(
    parameter int PC_W = risc_pkg::PC_W
) (
    input  logic [PC_W-1:0] pc,
    input  logic [7:0]      opcode,
    input  logic [PC_W-1:0] imm,
    input  logic            load,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_addr,
    output logic [PC_W-1:0] next_pc
);
    import risc_pkg::*;

    always_comb begin
        next_pc = pc;
        if (redirect_valid) begin
            next_pc = redirect_addr;
        end else if (load) begin
            next_pc = (opcode == OP_JMP) ? imm : pc + PC_W'(1);
        end
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, registers program memory data into a valid/ready
// slot, resolves jumps locally, takes execute redirects, stops on halt.
// Optional performance counters are built when INSTR_FETCH_PERF_EN is defined.
module instr_fetch_unit #(
    parameter int                     INSTR_W  = risc_pkg::INSTR_W,
    parameter int                     PC_W     = risc_pkg::PC_W,
    parameter logic [risc_pkg::PC_W-1:0] RESET_PC = '0
) (
    input  logic        clk_150_mhz,
    input  logic        rst_n,
    instr_fetch_unit_if.master bus
`ifdef INSTR_FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);
    import risc_pkg::*;

    fetch_state_t       state_p0;
    fetch_state_t       state_nxt;
    logic [PC_W-1:0]    pc_p0;
    logic [PC_W-1:0]    next_pc;
    logic [INSTR_W-1:0] inst_p1;
    logic [PC_W-1:0]    inst_pc_p1;
    logic               vld_p1;
    logic               load;
    logic [7:0]         opcode;

    assign opcode = bus.instruction[OPCODE_MSB:OPCODE_LSB];
    assign load   = (state_p0 == ST_RUN) && bus.fetch_en
                    && (!vld_p1 || bus.inst_ready) && !bus.redirect_valid;

    fetch_next_pc #(.PC_W(PC_W)) u_next_pc (
        .pc             (pc_p0),
        .opcode         (opcode),
        .imm            (bus.instruction[IMM_MSB:IMM_LSB]),
        .load           (load),
        .redirect_valid (bus.redirect_valid),
        .redirect_addr  (bus.redirect_addr),
        .next_pc        (next_pc)
    );

    // Redirect wins over a same-cycle halt load, and is the only way out of HALT.
    always_comb begin
        state_nxt = state_p0;
        if (bus.redirect_valid) begin
            state_nxt = ST_RUN;
        end else if (load && opcode == OP_HALT) begin
            state_nxt = ST_HALT;
        end
    end

    always_ff @(posedge clk_150_mhz) begin
        if (!rst_n) begin
            state_p0 <= ST_RUN;
            pc_p0    <= RESET_PC;
        end else begin
            state_p0 <= state_nxt;
            pc_p0    <= next_pc;
        end
    end

    // Stage p0 -> p1: memory read data captured into the output slot.
    always_ff @(posedge clk_150_mhz) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            inst_p1    <= '0;
            inst_pc_p1 <= '0;
        end else if (bus.redirect_valid) begin
            vld_p1 <= 1'b0;
        end else if (load) begin
            vld_p1     <= 1'b1;
            inst_p1    <= bus.instruction;
            inst_pc_p1 <= pc_p0;
        end else if (vld_p1 && bus.inst_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign bus.program_addr = pc_p0;
    assign bus.inst_valid   = vld_p1;
    assign bus.inst_out     = inst_p1;
    assign bus.inst_pc      = inst_pc_p1;
    assign bus.halted       = (state_p0 == ST_HALT);

`ifdef INSTR_FETCH_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk_150_mhz) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (load) perf_fetch_cnt <= sat_inc(perf_fetch_cnt);
            if (vld_p1 && !bus.inst_ready) perf_stall_cnt <= sat_inc(perf_stall_cnt);
        end
    end
`else
    // Counters and their ports are compiled out in this build.
`endif

endmodule
